// File: rtl/proj_to_affine.sv
// Projective (X:Y:Z) to affine (x,y) conversion over GF(p): drives an external
// inverter for Z^-1, then runs two MSB-first shift-add modular multipliers.
module proj_to_affine #(
    parameter int n       = 231,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] p,
    input  logic [n-1:0] Xp,
    input  logic [n-1:0] Yp,
    input  logic [n-1:0] Zp,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [n-1:0] x_aff,
    output logic [n-1:0] y_aff,
    output logic         inv_reset,
    output logic [n-1:0] inv_a,
    input  logic [n-1:0] inv_x,
    input  logic         inv_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int KW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [2:0] {IDLE, KICK, WAIT_INV, MUL, FIN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]  k_q, k_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           fail_q, fail_d;
    logic           inv_reset_q, inv_reset_d;
    logic [n-1:0]   inv_a_q, inv_a_d;
    logic [n-1:0]   x_aff_q, x_aff_d;
    logic [n-1:0]   y_aff_q, y_aff_d;
    logic [n-1:0]   x_q, x_d;
    logic [n-1:0]   y_q, y_d;
    logic [n-1:0]   zi_q, zi_d;
    logic [n-1:0]   ax_q, ax_d;
    logic [n-1:0]   ay_q, ay_d;

    // One interleaved step: acc <- (2*acc + bit*op) mod p, with an n+1 bit
    // intermediate so any p < 2^n is safe.
    function automatic logic [n-1:0] mod_step(input logic [n-1:0] acc,
                                              input logic [n-1:0] op,
                                              input logic [n-1:0] m,
                                              input logic         bit_k);
        logic [n:0] t;
        t = {acc, 1'b0};
        if (t >= {1'b0, m}) t = t - {1'b0, m};
        if (bit_k) begin
            t = t + {1'b0, op};
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end
        return t[n-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        done_d      = 1'b0;
        error_d     = error_q;
        fail_d      = fail_q;
        inv_reset_d = inv_reset_q;
        inv_a_d     = inv_a_q;
        x_aff_d     = x_aff_q;
        y_aff_d     = y_aff_q;
        x_d         = x_q;
        y_d         = y_q;
        zi_d        = zi_q;
        ax_d        = ax_q;
        ay_d        = ay_q;

        case (state_q)
            IDLE: begin
                inv_reset_d = 1'b1;
                // Starts coinciding with the done pulse are dropped.
                if (start && !done_q) begin
                    x_d     = Xp;
                    y_d     = Yp;
                    inv_a_d = Zp;
                    error_d = 1'b0;
                    if (Zp == '0) begin
                        fail_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        fail_d  = 1'b0;
                        state_d = KICK;
                    end
                end
            end
            KICK: begin
                inv_reset_d = 1'b0;
                cnt_d       = '0;
                state_d     = WAIT_INV;
            end
            WAIT_INV: begin
                if (inv_ready) begin
                    zi_d    = inv_x;
                    k_d     = KW'(n - 1);
                    ax_d    = '0;
                    ay_d    = '0;
                    state_d = MUL;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    fail_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MUL: begin
                ax_d = mod_step(ax_q, x_q, p, zi_q[k_q]);
                ay_d = mod_step(ay_q, y_q, p, zi_q[k_q]);
                k_d  = k_q - 1'b1;
                if (k_q == '0) state_d = FIN;
            end
            FIN: begin
                done_d      = 1'b1;
                error_d     = fail_q;
                x_aff_d     = fail_q ? '0 : ax_q;
                y_aff_d     = fail_q ? '0 : ay_q;
                inv_reset_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            fail_q      <= 1'b0;
            inv_reset_q <= 1'b1;
            inv_a_q     <= '0;
            x_aff_q     <= '0;
            y_aff_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            fail_q      <= fail_d;
            inv_reset_q <= inv_reset_d;
            inv_a_q     <= inv_a_d;
            x_aff_q     <= x_aff_d;
            y_aff_q     <= y_aff_d;
        end
    end

    // Operand and accumulator registers carry no reset; the FSM qualifies them.
    always_ff @(posedge clk) begin
        x_q  <= x_d;
        y_q  <= y_d;
        zi_q <= zi_d;
        ax_q <= ax_d;
        ay_q <= ay_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign x_aff     = x_aff_q;
    assign y_aff     = y_aff_q;
    assign inv_reset = inv_reset_q;
    assign inv_a     = inv_a_q;

endmodule

// File: tb/tb_proj_to_affine.sv
// Scoreboard bench for proj_to_affine (n=8, TIMEOUT=16) with a behavioural
// inverter stub that can be told never to answer.
module tb_proj_to_affine;

    localparam int N         = 8;
    localparam int TO        = 16;
    localparam int INV_DELAY = 3;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [N-1:0] p_in, xp, yp, zp;
    logic         busy, done, error;
    logic [N-1:0] x_aff, y_aff;
    logic         inv_reset;
    logic [N-1:0] inv_a;
    logic [N-1:0] inv_x = '0;
    logic         inv_ready = 1'b0;

    typedef struct {
        logic         err;
        logic [N-1:0] x;
        logic [N-1:0] y;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, start_cyc = 0, done_cyc = 0, rdy_cyc = 0, icnt = 0;
    bit   inv_live = 1'b1, got_done = 1'b0, saw_inv_low = 1'b0;

    proj_to_affine #(.n(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .p(p_in),
        .Xp(xp), .Yp(yp), .Zp(zp),
        .busy(busy), .done(done), .error(error),
        .x_aff(x_aff), .y_aff(y_aff),
        .inv_reset(inv_reset), .inv_a(inv_a),
        .inv_x(inv_x), .inv_ready(inv_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] modinv(input logic [N-1:0] a, input logic [N-1:0] m);
        logic [N-1:0] r;
        r = '0;
        for (int i = 1; i < int'(m); i++)
            if ((int'(a) * i) % int'(m) == 1) r = N'(i);
        return r;
    endfunction

    // Inverter stub: answers INV_DELAY+1 cycles after leaving reset, once.
    always @(posedge clk) begin
        if (inv_reset) begin
            icnt      <= 0;
            inv_ready <= 1'b0;
        end else begin
            icnt      <= icnt + 1;
            inv_ready <= inv_live && (icnt == INV_DELAY);
            inv_x     <= modinv(inv_a, p_in);
        end
    end

    always @(negedge clk) begin
        if (inv_ready) rdy_cyc <= cyc;
        if (!inv_reset) saw_inv_low <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every done pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: x=%0d y=%0d err=%0d with empty scoreboard", x_aff, y_aff, error);
                end else begin
                    e = sb.pop_front();
                    chk("error", 32'(error), 32'(e.err));
                    chk("x_aff", 32'(x_aff), 32'(e.x));
                    chk("y_aff", 32'(y_aff), 32'(e.y));
                end
            end
        end
    end

    task automatic issue(input int x, input int y, input int z, input bit push,
                         input bit e_err, input int ex, input int ey);
        exp_t e;
        @(negedge clk);
        xp = N'(x); yp = N'(y); zp = N'(z);
        start = 1'b1;
        start_cyc = cyc;
        if (push) begin
            e.err = e_err; e.x = N'(ex); e.y = N'(ey);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        got_done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!got_done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_wait: no done within %0d cycles, expected one", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        p_in = N'(23); xp = '0; yp = '0; zp = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_x_aff", 32'(x_aff), 0);
        chk("rst_y_aff", 32'(y_aff), 0);
        chk("rst_inv_reset", 32'(inv_reset), 1);
        chk("rst_inv_a", 32'(inv_a), 0);
        reset = 1'b0;

        // Basic conversion: 3^-1 = 8 mod 23.
        issue(5, 7, 3, 1'b1, 1'b0, 17, 10);
        wait_done(200);
        chk("mul_latency", 32'(done_cyc - rdy_cyc), 32'(N + 2));

        issue(22, 0, 1, 1'b1, 1'b0, 22, 0);
        wait_done(200);

        // Z == 0 short path: inverter never released.
        @(negedge clk);
        saw_inv_low = 1'b0;
        issue(9, 4, 0, 1'b1, 1'b1, 0, 0);
        wait_done(20);
        chk("zero_latency", 32'(done_cyc - start_cyc), 2);
        chk("zero_inv_held", 32'(saw_inv_low), 0);

        // Inverter timeout.
        inv_live = 1'b0;
        issue(5, 7, 3, 1'b1, 1'b1, 0, 0);
        wait_done(100);
        chk("timeout_latency", 32'(done_cyc - start_cyc), 32'(1 + TO + 2));
        inv_live = 1'b1;

        // Start during MUL and start on the done pulse are both ignored.
        issue(5, 7, 3, 1'b1, 1'b0, 17, 10);
        for (int i = 0; i < 50 && !inv_ready; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        xp = N'(10); yp = N'(4); zp = N'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_on_done_ignored", 32'(busy), 0);
        issue(10, 4, 2, 1'b1, 1'b0, 5, 2);
        wait_done(200);

        // Reset while waiting on the inverter.
        inv_live = 1'b0;
        issue(5, 7, 3, 1'b0, 1'b0, 0, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_error", 32'(error), 0);
        chk("abort_x_aff", 32'(x_aff), 0);
        chk("abort_y_aff", 32'(y_aff), 0);
        chk("abort_inv_reset", 32'(inv_reset), 1);
        reset = 1'b0;
        inv_live = 1'b1;
        repeat (25) @(negedge clk);
        issue(5, 7, 3, 1'b1, 1'b0, 17, 10);
        wait_done(200);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
